riscv_core_dcache_axi_write_master: RTL and testbench



---
 rtl/riscv_core_dcache_axi_write_master.sv | 155 +++++++++++++++
 tb/tb_riscv_core_dcache_axi_write_master.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_dcache_axi_write_master.sv
// Single-beat AXI4 write master for the D-cache write-through path.
// Turns one held controller store into one 64-bit AW/W burst, then pulses done once the B response arrives.
module riscv_core_dcache_axi_write_master #(
    parameter int ADDR_WIDTH      = 32,
    parameter int CORE_DATA_WIDTH = 32,
    parameter int AXI_DATA_WIDTH  = 64,
    localparam int STRB_WIDTH     = AXI_DATA_WIDTH / 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_mem_write_valid,
    input  logic [CORE_DATA_WIDTH-1:0] i_mem_write_data,
    input  logic [ADDR_WIDTH-1:0]     i_mem_write_address,
    input  logic [STRB_WIDTH-1:0]     i_mem_write_strobe,
    output logic                      o_mem_write_done,
    output logic                      o_write_err,
    output logic [ADDR_WIDTH-1:0]     o_awaddr,
    output logic                      o_awvalid,
    input  logic                      i_awready,
    output logic [7:0]                o_awlen,
    output logic [2:0]                o_awsize,
    output logic [1:0]                o_awburst,
    output logic [AXI_DATA_WIDTH-1:0] o_wdata,
    output logic [STRB_WIDTH-1:0]     o_wstrb,
    output logic                      o_wlast,
    output logic                      o_wvalid,
    input  logic                      i_wready,
    input  logic                      i_bvalid,
    input  logic [1:0]                i_bresp,
    output logic                      o_bready
);

    localparam int OFFSET_BITS = $clog2(STRB_WIDTH);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ADDR_DATA = 2'd1,
        RESP      = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                    state_reg;
    logic                      aw_ok_reg;
    logic                      w_ok_reg;
    logic                      awvalid_reg;
    logic                      wvalid_reg;
    logic                      bready_reg;
    logic                      done_reg;
    logic                      err_reg;
    logic [ADDR_WIDTH-1:0]     awaddr_reg;
    logic [AXI_DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_WIDTH-1:0]     wstrb_reg;

    logic [ADDR_WIDTH-1:0]     awaddr_next;
    logic [AXI_DATA_WIDTH-1:0] wdata_next;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      aw_complete;
    logic                      w_complete;

    // Store data is right-aligned from the core; place it on its byte lanes within the beat.
    always_comb begin
        awaddr_next = {i_mem_write_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        wdata_next  = AXI_DATA_WIDTH'(i_mem_write_data)
                      << {i_mem_write_address[OFFSET_BITS-1:0], 3'b000};
    end

    // A handshake in the current cycle counts towards completion so the FSM leaves ADDR_DATA without a bubble.
    always_comb begin
        aw_hs       = awvalid_reg & i_awready;
        w_hs        = wvalid_reg & i_wready;
        aw_complete = aw_ok_reg | aw_hs;
        w_complete  = w_ok_reg | w_hs;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            aw_ok_reg   <= 1'b0;
            w_ok_reg    <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    err_reg  <= 1'b0;
                    if (i_mem_write_valid) begin
                        awaddr_reg  <= awaddr_next;
                        wdata_reg   <= wdata_next;
                        wstrb_reg   <= i_mem_write_strobe;
                        awvalid_reg <= 1'b1;
                        wvalid_reg  <= 1'b1;
                        aw_ok_reg   <= 1'b0;
                        w_ok_reg    <= 1'b0;
                        state_reg   <= ADDR_DATA;
                    end
                end
                ADDR_DATA: begin
                    if (aw_hs) begin
                        awvalid_reg <= 1'b0;
                        aw_ok_reg   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_reg <= 1'b0;
                        w_ok_reg   <= 1'b1;
                    end
                    if (aw_complete && w_complete) begin
                        bready_reg <= 1'b1;
                        state_reg  <= RESP;
                    end
                end
                RESP: begin
                    if (i_bvalid) begin
                        bready_reg <= 1'b0;
                        done_reg   <= 1'b1;
                        err_reg    <= (i_bresp != 2'b00);
                        state_reg  <= DONE;
                    end
                end
                DONE: begin
                    // The request is still held high here; it must not be taken again.
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_awaddr         = awaddr_reg;
        o_awvalid        = awvalid_reg;
        o_awlen          = 8'd0;
        o_awsize         = 3'b011;
        o_awburst        = 2'b01;
        o_wdata          = wdata_reg;
        o_wstrb          = wstrb_reg;
        o_wlast          = 1'b1;
        o_wvalid         = wvalid_reg;
        o_bready         = bready_reg;
        o_mem_write_done = done_reg;
        o_write_err      = err_reg;
    end

endmodule

// File: tb/tb_riscv_core_dcache_axi_write_master.sv
// Directed bench for the D-cache AXI write master: alignment, stalls, error response, back-to-back and reset abort.
module tb_riscv_core_dcache_axi_write_master;

    logic        clk;
    logic        rst_n;
    logic        mem_write_valid;
    logic [31:0] mem_write_data;
    logic [31:0] mem_write_address;
    logic [7:0]  mem_write_strobe;
    logic        mem_write_done;
    logic        write_err;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;

    int n_checks;
    int n_fail;
    int aw_cnt;
    int w_cnt;
    int done_cnt;
    int aw_base;
    int w_base;
    int done_base;

    riscv_core_dcache_axi_write_master dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_mem_write_valid   (mem_write_valid),
        .i_mem_write_data    (mem_write_data),
        .i_mem_write_address (mem_write_address),
        .i_mem_write_strobe  (mem_write_strobe),
        .o_mem_write_done    (mem_write_done),
        .o_write_err         (write_err),
        .o_awaddr            (awaddr),
        .o_awvalid           (awvalid),
        .i_awready           (awready),
        .o_awlen             (awlen),
        .o_awsize            (awsize),
        .o_awburst           (awburst),
        .o_wdata             (wdata),
        .o_wstrb             (wstrb),
        .o_wlast             (wlast),
        .o_wvalid            (wvalid),
        .i_wready            (wready),
        .i_bvalid            (bvalid),
        .i_bresp             (bresp),
        .o_bready            (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake/pulse counters observed at the active edge.
    always @(posedge clk) begin
        if (awvalid && awready) aw_cnt <= aw_cnt + 1;
        if (wvalid && wready) w_cnt <= w_cnt + 1;
        if (mem_write_done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb);
        mem_write_valid   = 1'b1;
        mem_write_address = addr;
        mem_write_data    = data;
        mem_write_strobe  = strb;
        $display("request addr=0x%08h data=0x%08h strb=0x%02h", addr, data, strb);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        aw_cnt   = 0;
        w_cnt    = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        mem_write_valid   = 1'b0;
        mem_write_data    = '0;
        mem_write_address = '0;
        mem_write_strobe  = '0;
        awready = 1'b1;
        wready  = 1'b1;
        bvalid  = 1'b1;
        bresp   = 2'b00;

        // Reset state
        tick();
        tick();
        check_eq("rst_awvalid", awvalid, 1'b0);
        check_eq("rst_wvalid", wvalid, 1'b0);
        check_eq("rst_bready", bready, 1'b0);
        check_eq("rst_done", mem_write_done, 1'b0);
        check_eq("rst_err", write_err, 1'b0);
        check_eq("rst_awaddr", awaddr, 32'h0);
        check_eq("rst_wdata", wdata, 64'h0);
        check_eq("rst_wstrb", wstrb, 8'h0);
        check_eq("const_awlen", awlen, 8'h00);
        check_eq("const_awsize", awsize, 3'b011);
        check_eq("const_awburst", awburst, 2'b01);
        check_eq("const_wlast", wlast, 1'b1);
        rst_n = 1'b1;
        tick();

        // Aligned word store, best-case latency
        request(32'h1000_0004, 32'hDEAD_BEEF, 8'hF0);
        tick(); // c1
        check_eq("t1_awvalid", awvalid, 1'b1);
        check_eq("t1_wvalid", wvalid, 1'b1);
        check_eq("t1_awaddr", awaddr, 32'h1000_0000);
        check_eq("t1_wdata", wdata, 64'hDEAD_BEEF_0000_0000);
        check_eq("t1_wstrb", wstrb, 8'hF0);
        check_eq("t1_bready_c1", bready, 1'b0);
        tick(); // c2
        check_eq("t1_bready_c2", bready, 1'b1);
        check_eq("t1_awvalid_c2", awvalid, 1'b0);
        check_eq("t1_wvalid_c2", wvalid, 1'b0);
        check_eq("t1_done_c2", mem_write_done, 1'b0);
        tick(); // c3, valid still held
        check_eq("t1_done_c3", mem_write_done, 1'b1);
        check_eq("t1_err_c3", write_err, 1'b0);
        check_eq("t1_bready_c3", bready, 1'b0);
        tick(); // c4
        check_eq("t1_done_c4", mem_write_done, 1'b0);
        check_eq("t1_no_reaccept", awvalid, 1'b0);
        mem_write_valid = 1'b0;
        tick();
        check_eq("t1_idle_c5", awvalid, 1'b0);

        // Byte store
        request(32'h2000_0003, 32'h0000_00AB, 8'h08);
        tick();
        check_eq("t2_awaddr", awaddr, 32'h2000_0000);
        check_eq("t2_wdata", wdata, 64'h0000_0000_AB00_0000);
        check_eq("t2_wstrb", wstrb, 8'h08);
        tick();
        tick();
        check_eq("t2_done", mem_write_done, 1'b1);
        tick();
        mem_write_valid = 1'b0;
        tick();

        // Skewed ready: awready low for three cycles
        request(32'h3000_0010, 32'h1234_5678, 8'h0F);
        awready = 1'b0;
        tick(); // c1
        check_eq("t3_awvalid_c1", awvalid, 1'b1);
        check_eq("t3_wvalid_c1", wvalid, 1'b1);
        tick(); // c2
        check_eq("t3_wvalid_c2", wvalid, 1'b0);
        check_eq("t3_awvalid_c2", awvalid, 1'b1);
        check_eq("t3_awaddr_c2", awaddr, 32'h3000_0010);
        tick(); // c3
        check_eq("t3_awvalid_c3", awvalid, 1'b1);
        check_eq("t3_awaddr_c3", awaddr, 32'h3000_0010);
        check_eq("t3_done_c3", mem_write_done, 1'b0);
        tick(); // c4
        check_eq("t3_awvalid_c4", awvalid, 1'b1);
        awready = 1'b1;
        tick(); // c5
        check_eq("t3_awvalid_c5", awvalid, 1'b0);
        check_eq("t3_bready_c5", bready, 1'b1);
        check_eq("t3_done_c5", mem_write_done, 1'b0);
        tick(); // c6
        check_eq("t3_done_c6", mem_write_done, 1'b1);
        tick();
        mem_write_valid = 1'b0;
        tick();

        // Error response after two bvalid delay cycles
        bvalid = 1'b0;
        bresp  = 2'b10;
        request(32'h4000_0008, 32'hCAFE_F00D, 8'h0F);
        tick(); // c1
        tick(); // c2
        check_eq("t4_bready_c2", bready, 1'b1);
        check_eq("t4_done_c2", mem_write_done, 1'b0);
        tick(); // c3
        check_eq("t4_bready_c3", bready, 1'b1);
        check_eq("t4_done_c3", mem_write_done, 1'b0);
        tick(); // c4
        bvalid = 1'b1;
        tick(); // c5
        check_eq("t4_done_c5", mem_write_done, 1'b1);
        check_eq("t4_err_c5", write_err, 1'b1);
        tick(); // c6
        check_eq("t4_done_c6", mem_write_done, 1'b0);
        check_eq("t4_err_c6", write_err, 1'b0);
        mem_write_valid = 1'b0;
        bresp = 2'b00;
        tick();

        // Back-to-back writes
        aw_base   = aw_cnt;
        w_base    = w_cnt;
        done_base = done_cnt;
        request(32'h5000_0000, 32'h1111_1111, 8'h0F);
        tick();
        tick();
        tick(); // c3 done
        check_eq("t5_done_a", mem_write_done, 1'b1);
        tick(); // c4 idle, second request presented
        request(32'h5000_0104, 32'h2222_2222, 8'hF0);
        tick();
        check_eq("t5_accept_b", awvalid, 1'b1);
        check_eq("t5_awaddr_b", awaddr, 32'h5000_0100);
        check_eq("t5_wdata_b", wdata, 64'h2222_2222_0000_0000);
        tick();
        tick();
        check_eq("t5_done_b", mem_write_done, 1'b1);
        tick();
        mem_write_valid = 1'b0;
        tick();
        tick();
        check_eq("t5_aw_count", 64'(aw_cnt - aw_base), 64'd2);
        check_eq("t5_w_count", 64'(w_cnt - w_base), 64'd2);
        check_eq("t5_done_count", 64'(done_cnt - done_base), 64'd2);

        // Reset asserted during RESP
        bvalid = 1'b0;
        done_base = done_cnt;
        request(32'h6000_0002, 32'h0000_BEEF, 8'h0C);
        tick();
        tick(); // RESP
        check_eq("t6_bready_resp", bready, 1'b1);
        #3;
        rst_n = 1'b0;
        mem_write_valid = 1'b0;
        #1;
        check_eq("t6_rst_bready", bready, 1'b0);
        check_eq("t6_rst_awaddr", awaddr, 32'h0);
        check_eq("t6_rst_wdata", wdata, 64'h0);
        check_eq("t6_rst_wstrb", wstrb, 8'h0);
        check_eq("t6_rst_done", mem_write_done, 1'b0);
        bvalid = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("t6_no_done", 64'(done_cnt - done_base), 64'd0);
        request(32'h7000_0000, 32'hA5A5_A5A5, 8'h0F);
        tick();
        check_eq("t6_after_awaddr", awaddr, 32'h7000_0000);
        check_eq("t6_after_wdata", wdata, 64'h0000_0000_A5A5_A5A5);
        tick();
        tick();
        check_eq("t6_after_done", mem_write_done, 1'b1);
        tick();
        mem_write_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
